bcd_stopwatch4: RTL and testbench

Four-digit BCD up/down counter (stopwatch) that generates the digit values fed to the four BCD-to-seven-segment decoder instances driving HEX0..HEX3. It runs from the 50 MHz board clock and derives a counting tick with an internal prescaler. Pushbuttons start, stop and clear it, and a switch selects the count direction. It is the stage directly upstream of the display decoders.

---
 rtl/bcd_stopwatch4_pkg.sv | 30 +++
 rtl/bcd_stopwatch4_digit.sv | 36 +++
 rtl/bcd_stopwatch4.sv | 190 +++++++++++++++++++
 tb/tb_bcd_stopwatch4.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/bcd_stopwatch4_pkg.sv
// Shared types, constants and BCD helpers for the four-digit stopwatch.
package bcd_stopwatch4_pkg;

  typedef enum logic {
    StStopped = 1'b0,
    StRunning = 1'b1
  } sw_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // True when a step in the given direction leaves the decade.
  // Codes 10..15 act as 9 going up and as 0 going down.
  function automatic logic bcd_at_limit(input logic [3:0] v, input logic up);
    if (up) begin
      return v >= BCD_MAX;
    end else begin
      return (v == BCD_MIN) || (v > BCD_MAX);
    end
  endfunction

  function automatic logic [3:0] bcd_step(input logic [3:0] v, input logic up);
    if (up) begin
      return bcd_at_limit(v, 1'b1) ? BCD_MIN : v + 4'd1;
    end else begin
      return bcd_at_limit(v, 1'b0) ? BCD_MAX : v - 4'd1;
    end
  endfunction

endpackage

// File: rtl/bcd_stopwatch4_digit.sv
// One BCD decade with synchronous clear and ripple carry/borrow out.
module bcd_digit
  import bcd_stopwatch4_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       up_i,
  input  logic       clr_i,
  output logic [3:0] value_o,
  output logic       co_o
);

  logic [3:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = BCD_MIN;
    end else if (en_i) begin
      value_d = bcd_step(value_q, up_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= BCD_MIN;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;
  assign co_o    = en_i & bcd_at_limit(value_q, up_i);

endmodule

// File: rtl/bcd_stopwatch4.sv
// Four-digit BCD up/down stopwatch: synchronised buttons, run FSM, prescaler, digit chain.
module bcd_stopwatch4
  import bcd_stopwatch4_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned TICK_HZ     = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLOCK_50,
  input  logic [2:0] KEY,
  input  logic [0:0] SW,
  output logic [3:0] DIG0,
  output logic [3:0] DIG1,
  output logic [3:0] DIG2,
  output logic [3:0] DIG3,
  output logic       LEDG0,
  output logic       LEDR0
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic clk;
  logic rst_n;
  assign clk   = CLOCK_50;
  assign rst_n = KEY[0];

  // Synchronisers: bit 0 = KEY[1], bit 1 = KEY[2], bit 2 = SW[0]; reset to released.
  logic [2:0]                  sync_in;
  logic [2:0][SYNC_STAGES-1:0] sync_q;
  logic [2:0]                  sync_out;

  assign sync_in = {SW[0], KEY[2], KEY[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], sync_in[i]};
      end
    end
  end

  always_comb begin
    sync_out = '0;
    for (int i = 0; i < 3; i++) begin
      sync_out[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // Registered falling-edge detect gives one-cycle press pulses.
  logic [1:0] key_last_q;
  logic [1:0] press_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_last_q <= 2'b11;
      press_q    <= 2'b00;
    end else begin
      key_last_q <= sync_out[1:0];
      press_q    <= key_last_q & ~sync_out[1:0];
    end
  end

  logic startstop;
  logic clear;
  logic up;
  assign startstop = press_q[0];
  assign clear     = press_q[1];
  assign up        = ~sync_out[2];

  // Run state machine.
  sw_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (startstop) begin
      unique case (state_q)
        StStopped: state_d = StRunning;
        StRunning: state_d = StStopped;
        default:   state_d = StStopped;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StStopped;
    end else begin
      state_q <= state_d;
    end
  end

  // Prescaler only advances while running now and next cycle; zero otherwise.
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  assign tick = (state_q == StRunning) && (pre_q == PRE_LAST);

  always_comb begin
    pre_d = pre_q;
    if (clear || (state_q != StRunning) || (state_d != StRunning) || tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  // Decade chain: each enable is the previous decade's carry/borrow out.
  logic [3:0] d0, d1, d2, d3;
  logic       co0, co1, co2, co3;

  bcd_digit u_dig0 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (tick),
    .up_i    (up),
    .clr_i   (clear),
    .value_o (d0),
    .co_o    (co0)
  );

  bcd_digit u_dig1 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (co0),
    .up_i    (up),
    .clr_i   (clear),
    .value_o (d1),
    .co_o    (co1)
  );

  bcd_digit u_dig2 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (co1),
    .up_i    (up),
    .clr_i   (clear),
    .value_o (d2),
    .co_o    (co2)
  );

  bcd_digit u_dig3 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (co2),
    .up_i    (up),
    .clr_i   (clear),
    .value_o (d3),
    .co_o    (co3)
  );

  // Sticky wrap flag; clear takes priority over a coincident wrap.
  logic wrap_q, wrap_d;

  always_comb begin
    wrap_d = wrap_q;
    if (clear) begin
      wrap_d = 1'b0;
    end else if (co3) begin
      wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign DIG0  = d0;
  assign DIG1  = d1;
  assign DIG2  = d2;
  assign DIG3  = d3;
  assign LEDG0 = (state_q == StRunning);
  assign LEDR0 = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch4.sv
// Directed bench for bcd_stopwatch4 at DIV=10, SYNC_STAGES=2.
module tb_bcd_stopwatch4;

  logic       clk = 1'b0;
  logic [2:0] key;
  logic [0:0] sw;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic       ledg0, ledr0;
  logic [15:0] digits;

  int unsigned n_vec = 0;
  int unsigned n_miscompare = 0;

  always #5 clk = ~clk;

  assign digits = {dig3, dig2, dig1, dig0};

  bcd_stopwatch4 #(
    .CLK_HZ      (10),
    .TICK_HZ     (1),
    .SYNC_STAGES (2)
  ) dut (
    .CLOCK_50 (clk),
    .KEY      (key),
    .SW       (sw),
    .DIG0     (dig0),
    .DIG1     (dig1),
    .DIG2     (dig2),
    .DIG3     (dig3),
    .LEDG0    (ledg0),
    .LEDR0    (ledr0)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    step(10 * n);
  endtask

  // One-cycle low pulse on a button, launched at a negedge.
  task automatic press(input int idx);
    key[idx] = 1'b0;
    step(1);
    key[idx] = 1'b1;
  endtask

  // Bounded poll for the run LED; ends on the negedge right after the state edge.
  task automatic wait_led(input logic exp, input string tag);
    for (int i = 0; i < 20; i++) begin
      if (ledg0 === exp) break;
      step(1);
    end
    check(tag, 16'(ledg0), 16'(exp));
  endtask

  initial begin
    key = 3'b110;
    sw  = 1'b0;
    step(3);
    key[0] = 1'b1;
    step(50);
    check("idle_digits", digits, 16'h0000);
    check("idle_ledg", 16'(ledg0), 16'h0);
    check("idle_ledr", 16'(ledr0), 16'h0);

    // Start, count up; first increment exactly DIV cycles after LEDG0 rises.
    press(1);
    wait_led(1'b1, "start_ledg");
    step(9);
    check("pre_first_tick", digits, 16'h0000);
    step(1);
    check("first_tick", digits, 16'h0001);
    ticks(1);
    check("second_tick", digits, 16'h0002);

    // Up carry and down borrow.
    ticks(7);
    check("up_0009", digits, 16'h0009);
    ticks(1);
    check("up_carry_0010", digits, 16'h0010);
    ticks(90);
    check("up_0100", digits, 16'h0100);
    sw = 1'b1;
    ticks(1);
    check("down_borrow_0099", digits, 16'h0099);
    ticks(1);
    check("down_0098", digits, 16'h0098);
    ticks(98);
    check("down_0000", digits, 16'h0000);
    check("down_0000_ledr", 16'(ledr0), 16'h0);
    ticks(1);
    check("down_wrap_9999", digits, 16'h9999);
    check("down_wrap_ledr", 16'(ledr0), 16'h1);
    sw = 1'b0;
    ticks(1);
    check("up_wrap_0000", digits, 16'h0000);
    check("up_wrap_ledr", 16'(ledr0), 16'h1);
    ticks(1);
    check("ledr_sticky_0001", digits, 16'h0001);
    check("ledr_sticky", 16'(ledr0), 16'h1);

    // Clear pulse lands in the tick cycle: clear wins, prescaler restarts.
    ticks(346);
    check("run_0347", digits, 16'h0347);
    step(6);
    press(2);
    step(3);
    check("clear_digits", digits, 16'h0000);
    check("clear_ledr", 16'(ledr0), 16'h0);
    check("clear_ledg", 16'(ledg0), 16'h1);
    step(9);
    check("clear_hold", digits, 16'h0000);
    step(1);
    check("clear_next_tick", digits, 16'h0001);

    // Asynchronous reset between clock edges.
    ticks(1233);
    check("run_1234", digits, 16'h1234);
    step(1);
    #1 key[0] = 1'b0;
    #1;
    check("async_rst_digits", digits, 16'h0000);
    check("async_rst_ledg", 16'(ledg0), 16'h0);
    check("async_rst_ledr", 16'(ledr0), 16'h0);
    step(2);
    key[0] = 1'b1;
    step(30);
    check("post_rst_digits", digits, 16'h0000);
    check("post_rst_stopped", 16'(ledg0), 16'h0);

    // Start then stop: digits freeze.
    press(1);
    wait_led(1'b1, "restart_ledg");
    ticks(3);
    check("restart_0003", digits, 16'h0003);
    press(1);
    wait_led(1'b0, "stop_ledg");
    step(50);
    check("stopped_hold", digits, 16'h0003);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
